// File: rtl/sobel_stream_engine.sv
// Streaming 3x3 Sobel edge engine: raster pixels are written over a strobed bus,
// interior-pixel results are queued in a FIFO and read back over the same bus.
module sobel_stream_engine #(
  parameter int PIX_W      = 8,
  parameter int IMG_W      = 64,
  parameter int IMG_H      = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PIX_W-1:0] bus_in,
  output logic [PIX_W-1:0] bus_out,
  input  logic             data_strobe,
  input  logic             bus_rw,
  input  logic             sof,
  input  logic             mode,
  input  logic [PIX_W-1:0] threshold,
  output logic             fifo_empty,
  output logic             fifo_full,
  output logic             overflow
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = PIX_W + 3;
  localparam int MW = PIX_W + 4;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [MW-1:0] SAT      = {4'b0000, {PIX_W{1'b1}}};
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({3'b000, p});
  endfunction

  logic             wr_arm_r, rd_arm_r, hi_seen_r;
  logic             wr_acc_s, rd_acc_s;
  logic [CW-1:0]    col_r, cur_col_s, col_nxt_s;
  logic [RW-1:0]    row_r, cur_row_s, row_nxt_s;
  logic             win_ok_s, win_vld_r;
  logic [PIX_W-1:0] lb1_r [IMG_W];
  logic [PIX_W-1:0] lb2_r [IMG_W];
  logic [PIX_W-1:0] win_r [3][3];
  logic signed [GW-1:0] gx_s, gy_s, gx_r, gy_r;
  logic             s1_vld_r;
  logic [GW-1:0]    ax_s, ay_s;
  logic [MW-1:0]    mag_s;
  logic [PIX_W-1:0] sat_s, res_s;
  logic [PIX_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [AW:0]      cnt_r, cnt_nxt_s;
  logic             pop_s, do_push_s, drop_s;

  // A held-low strobe is one transaction; after reset the strobe must be seen high first.
  assign wr_acc_s = !data_strobe && !bus_rw && wr_arm_r && hi_seen_r;
  assign rd_acc_s = !data_strobe &&  bus_rw && rd_arm_r && hi_seen_r;

  // Transaction arm flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_arm_r  <= 1'b1;
      rd_arm_r  <= 1'b1;
      hi_seen_r <= 1'b0;
    end else if (data_strobe) begin
      wr_arm_r  <= 1'b1;
      rd_arm_r  <= 1'b1;
      hi_seen_r <= 1'b1;
    end else begin
      if (wr_acc_s) wr_arm_r <= 1'b0;
      if (rd_acc_s) rd_arm_r <= 1'b0;
    end
  end

  // Raster position of the incoming pixel and where the next one lands.
  always_comb begin
    cur_col_s = sof ? '0 : col_r;
    cur_row_s = sof ? '0 : row_r;
    win_ok_s  = (cur_row_s >= RW'(2)) && (cur_col_s >= CW'(2));
    row_nxt_s = cur_row_s;
    if (cur_col_s == COL_LAST) begin
      col_nxt_s = '0;
      row_nxt_s = (cur_row_s == ROW_LAST) ? '0 : cur_row_s + RW'(1);
    end else begin
      col_nxt_s = cur_col_s + CW'(1);
    end
  end

  // Line buffers hold the two previous rows; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      lb2_r[cur_col_s] <= lb1_r[cur_col_s];
      lb1_r[cur_col_s] <= bus_in;
    end
  end

  // Counters and the 3x3 window, shifted left by one column per accepted pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_r     <= '0;
      row_r     <= '0;
      win_vld_r <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_r[r][c] <= '0;
    end else if (wr_acc_s) begin
      col_r     <= col_nxt_s;
      row_r     <= row_nxt_s;
      win_vld_r <= win_ok_s;
      for (int r = 0; r < 3; r++) begin
        win_r[r][0] <= win_r[r][1];
        win_r[r][1] <= win_r[r][2];
      end
      win_r[0][2] <= lb2_r[cur_col_s];
      win_r[1][2] <= lb1_r[cur_col_s];
      win_r[2][2] <= bus_in;
    end else begin
      win_vld_r <= 1'b0;
    end
  end

  assign gx_s = (ext(win_r[0][2]) + (ext(win_r[1][2]) <<< 1) + ext(win_r[2][2]))
              - (ext(win_r[0][0]) + (ext(win_r[1][0]) <<< 1) + ext(win_r[2][0]));
  assign gy_s = (ext(win_r[2][0]) + (ext(win_r[2][1]) <<< 1) + ext(win_r[2][2]))
              - (ext(win_r[0][0]) + (ext(win_r[0][1]) <<< 1) + ext(win_r[0][2]));

  // Stage 1: gradient registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gx_r     <= '0;
      gy_r     <= '0;
      s1_vld_r <= 1'b0;
    end else begin
      gx_r     <= gx_s;
      gy_r     <= gy_s;
      s1_vld_r <= win_vld_r;
    end
  end

  // Stage 2: magnitude, saturation and optional threshold, pushed straight into the FIFO.
  always_comb begin
    ax_s  = gx_r[GW-1] ? GW'(-gx_r) : GW'(gx_r);
    ay_s  = gy_r[GW-1] ? GW'(-gy_r) : GW'(gy_r);
    mag_s = {1'b0, ax_s} + {1'b0, ay_s};
    sat_s = (mag_s > SAT) ? {PIX_W{1'b1}} : mag_s[PIX_W-1:0];
    if (mode) begin
      res_s = (mag_s >= {4'b0000, threshold}) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
    end else begin
      res_s = sat_s;
    end
  end

  assign pop_s     = rd_acc_s && !fifo_empty;
  assign do_push_s = s1_vld_r && (!fifo_full || pop_s);
  assign drop_s    = s1_vld_r && fifo_full && !pop_s;

  // FIFO occupancy after this edge.
  always_comb begin
    cnt_nxt_s = cnt_r;
    case ({do_push_s, pop_s})
      2'b10:   cnt_nxt_s = cnt_r + (AW+1)'(1);
      2'b01:   cnt_nxt_s = cnt_r - (AW+1)'(1);
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // FIFO storage; a push and pop in the same edge may target the same slot when full.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= res_s;
  end

  // FIFO control, flags and registered read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      cnt_r      <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      overflow   <= 1'b0;
      bus_out    <= {PIX_W{1'b1}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
        bus_out  <= mem_r[rd_ptr_r];
      end
      if (drop_s) overflow <= 1'b1;
      cnt_r      <= cnt_nxt_s;
      fifo_empty <= (cnt_nxt_s == '0);
      fifo_full  <= (cnt_nxt_s == CNT_FULL);
    end
  end

endmodule

// File: tb/tb_sobel_stream_engine.sv
// Scoreboard bench for sobel_stream_engine on 4x4 frames; instance a has an
// 8-deep result FIFO, instance b a 2-deep one for the overflow scenario.
module tb_sobel_stream_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] bus_in = 8'h00;
  logic       data_strobe = 1'b1;
  logic       bus_rw = 1'b0;
  logic       sof = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] threshold = 8'h00;
  logic [7:0] bus_out_a, bus_out_b;
  logic       empty_a, full_a, ovf_a, empty_b, full_b, ovf_b;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         img[4][4];
  logic [7:0] rd_a, rd_b;

  always #5 clk = ~clk;

  sobel_stream_engine #(.PIX_W(8), .IMG_W(4), .IMG_H(4), .FIFO_DEPTH(8)) dut_a (
    .clk(clk), .reset(reset), .bus_in(bus_in), .bus_out(bus_out_a),
    .data_strobe(data_strobe), .bus_rw(bus_rw), .sof(sof), .mode(mode),
    .threshold(threshold), .fifo_empty(empty_a), .fifo_full(full_a), .overflow(ovf_a));

  sobel_stream_engine #(.PIX_W(8), .IMG_W(4), .IMG_H(4), .FIFO_DEPTH(2)) dut_b (
    .clk(clk), .reset(reset), .bus_in(bus_in), .bus_out(bus_out_b),
    .data_strobe(data_strobe), .bus_rw(bus_rw), .sof(sof), .mode(mode),
    .threshold(threshold), .fifo_empty(empty_b), .fifo_full(full_b), .overflow(ovf_b));

  function automatic logic [7:0] model(int r, int c, logic md, logic [7:0] thr);
    int gx, gy, mag;
    gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
    gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
       - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (mag > 255) mag = 255;
    if (md) return (mag >= int'(thr)) ? 8'hFF : 8'h00;
    return mag[7:0];
  endfunction

  task automatic fill_step();
    for (int i = 0; i < 16; i++) img[i/4][i%4] = ((i % 4) >= 2) ? 100 : 0;
  endtask

  task automatic fill_uniform(input int v);
    for (int i = 0; i < 16; i++) img[i/4][i%4] = v;
  endtask

  task automatic fill_rand(input int mx);
    for (int i = 0; i < 16; i++) img[i/4][i%4] = int'($urandom_range(0, mx));
  endtask

  task automatic expect_frame();
    for (int r = 1; r <= 2; r++)
      for (int c = 1; c <= 2; c++) exp_q.push_back(model(r, c, mode, threshold));
  endtask

  task automatic do_reset();
    reset = 1'b0; data_strobe = 1'b1; bus_rw = 1'b0; sof = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_q.delete();
  endtask

  task automatic write_pix(input logic [7:0] p, input logic s, input int hold);
    bus_in = p; sof = s; bus_rw = 1'b0; data_strobe = 1'b0;
    repeat (hold) @(negedge clk);
    data_strobe = 1'b1; sof = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_pix(input int hold);
    bus_rw = 1'b1; data_strobe = 1'b0;
    repeat (hold) @(negedge clk);
    data_strobe = 1'b1; bus_rw = 1'b0;
    @(negedge clk);
    rd_a = bus_out_a; rd_b = bus_out_b;
  endtask

  task automatic send_pixels(input int first, input int last, input logic first_sof, input int hold_idx);
    for (int i = first; i <= last; i++)
      write_pix(img[i/4][i%4][7:0], (i == first) && first_sof, (i == hold_idx) ? 10 : 1);
  endtask

  task automatic drain(input string name);
    logic [7:0] e;
    repeat (4) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      read_pix(1);
      checks++;
      if (rd_a !== e) begin
        failures++;
        $display("FAIL %s: result got %02h expected %02h", name, rd_a, e);
      end
    end
    checks++;
    if (empty_a !== 1'b1) begin
      failures++;
      $display("FAIL %s_empty: fifo_empty got %b expected 1", name, empty_a);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 4;
    if (bus_out_a !== 8'hFF) begin failures++; $display("FAIL reset_bus_out: got %02h expected ff", bus_out_a); end
    if (empty_a !== 1'b1)    begin failures++; $display("FAIL reset_empty: got %b expected 1", empty_a); end
    if (full_a !== 1'b0)     begin failures++; $display("FAIL reset_full: got %b expected 0", full_a); end
    if (ovf_a !== 1'b0)      begin failures++; $display("FAIL reset_overflow: got %b expected 0", ovf_a); end
    read_pix(1);
    checks += 2;
    if (rd_a !== 8'hFF)   begin failures++; $display("FAIL empty_read: got %02h expected ff", rd_a); end
    if (empty_a !== 1'b1) begin failures++; $display("FAIL empty_read_flag: got %b expected 1", empty_a); end
  endtask

  task automatic test_magnitude();
    do_reset();
    mode = 1'b0;
    fill_step(); expect_frame(); send_pixels(0, 15, 1'b1, -1); drain("step_mag");
    fill_rand(31); expect_frame(); send_pixels(0, 15, 1'b1, -1); drain("rand_small_mag");
    fill_rand(255); expect_frame(); send_pixels(0, 15, 1'b1, -1); drain("rand_full_mag");
  endtask

  task automatic test_threshold();
    do_reset();
    mode = 1'b1; threshold = 8'd1;
    fill_uniform(50); expect_frame(); send_pixels(0, 15, 1'b1, -1); drain("uniform_thr");
    threshold = 8'd200;
    fill_step(); expect_frame(); send_pixels(0, 15, 1'b1, -1); drain("step_thr");
    threshold = 8'd60;
    fill_rand(31); expect_frame(); send_pixels(0, 15, 1'b1, -1); drain("rand_thr");
    mode = 1'b0;
  endtask

  task automatic test_strobe_hold();
    logic [7:0] e;
    do_reset();
    fill_rand(31); expect_frame();
    send_pixels(0, 15, 1'b1, 5);
    repeat (4) @(negedge clk);
    e = exp_q.pop_front();
    read_pix(10);
    checks++;
    if (rd_a !== e) begin failures++; $display("FAIL held_read: got %02h expected %02h", rd_a, e); end
    drain("strobe_hold");
  endtask

  task automatic test_overflow();
    do_reset();
    fill_step();
    send_pixels(0, 11, 1'b1, -1);
    repeat (3) @(negedge clk);
    checks += 3;
    if (full_b !== 1'b1)  begin failures++; $display("FAIL ovf_full2: got %b expected 1", full_b); end
    if (ovf_b !== 1'b0)   begin failures++; $display("FAIL ovf_early: got %b expected 0", ovf_b); end
    if (empty_b !== 1'b0) begin failures++; $display("FAIL ovf_nonempty: got %b expected 0", empty_b); end
    send_pixels(12, 14, 1'b0, -1);
    repeat (3) @(negedge clk);
    checks++;
    if (ovf_b !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b expected 1", ovf_b); end
    send_pixels(15, 15, 1'b0, -1);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      read_pix(1);
      checks++;
      if (rd_b !== 8'd255) begin failures++; $display("FAIL ovf_read%0d: got %02h expected ff", k, rd_b); end
    end
    checks += 2;
    if (empty_b !== 1'b1) begin failures++; $display("FAIL ovf_drained: got %b expected 1", empty_b); end
    if (ovf_b !== 1'b1)   begin failures++; $display("FAIL ovf_sticky: got %b expected 1", ovf_b); end
  endtask

  task automatic test_mid_sof();
    do_reset();
    fill_rand(255);
    send_pixels(0, 5, 1'b1, -1);
    fill_rand(31); expect_frame();
    send_pixels(0, 15, 1'b1, -1);
    drain("mid_sof");
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    do_reset();
    fill_rand(31); expect_frame();
    send_pixels(0, 15, 1'b1, -1);
    repeat (4) @(negedge clk);
    e = exp_q.pop_front();
    read_pix(1);
    checks++;
    if (rd_a !== e) begin failures++; $display("FAIL pre_reset_read: got %02h expected %02h", rd_a, e); end
    exp_q.delete();
    fill_rand(255);
    send_pixels(0, 4, 1'b1, -1);
    bus_in = 8'd200; sof = 1'b1; bus_rw = 1'b0; data_strobe = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks += 4;
    if (bus_out_a !== 8'hFF) begin failures++; $display("FAIL midreset_bus_out: got %02h expected ff", bus_out_a); end
    if (empty_a !== 1'b1)    begin failures++; $display("FAIL midreset_empty: got %b expected 1", empty_a); end
    if (full_b !== 1'b0)     begin failures++; $display("FAIL midreset_full: got %b expected 0", full_b); end
    if (ovf_b !== 1'b0)      begin failures++; $display("FAIL midreset_overflow: got %b expected 0", ovf_b); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    data_strobe = 1'b1; sof = 1'b0;
    @(negedge clk);
    fill_rand(31); expect_frame();
    send_pixels(0, 15, 1'b0, -1);
    drain("post_reset_frame");
  endtask

  initial begin
    test_reset();
    test_magnitude();
    test_threshold();
    test_strobe_hold();
    test_overflow();
    test_mid_sof();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sobel_stream_engine.md
Name: sobel_stream_engine

Overview:
Parametrised successor to the single-window Sobel bus block. It accepts a raster pixel stream over the strobed bus, one pixel per write transaction, and keeps two internal line buffers to form 3x3 windows. It computes a saturated |Gx|+|Gy| or a thresholded binary edge value per interior pixel, queues results in an output FIFO, and returns them over the same bus on read transactions.

Parameters:
PIX_W, 8, pixel and result width in bits (4..16)
IMG_W, 64, pixels per line (>=3)
IMG_H, 64, lines per frame (>=3)
FIFO_DEPTH, 8, result FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous active-low reset
bus_in  in  PIX_W  pixel data for write transactions
bus_out  out  PIX_W  result data, registered
data_strobe  in  1  active-low transaction strobe
bus_rw  in  1  1=READ, 0=WRITE
sof  in  1  start of frame, sampled with a write; marks that pixel as row 0 col 0
mode  in  1  0=magnitude output, 1=binary threshold output
threshold  in  PIX_W  threshold for mode 1
fifo_empty  out  1  result FIFO empty
fifo_full  out  1  result FIFO full
overflow  out  1  sticky: a result was dropped because the FIFO was full

Behaviour:
- Reset (reset=0, async): bus_out=all ones; col=row=0; FIFO empty (fifo_empty=1, fifo_full=0); overflow=0; pipeline valids=0; arm flags set. Line buffer contents are don't-care.
- Transaction acceptance: there are separate wr_arm and rd_arm flags.
  - A write is accepted on the first rising edge with data_strobe=0, bus_rw=0 and wr_arm=1. That edge clears wr_arm.
  - A read is accepted the same way with bus_rw=1 and rd_arm=1. That edge clears rd_arm.
  - Both flags set again on any edge with data_strobe=1.
  - A strobe held low for many cycles counts as exactly one transaction.
- Write path:
  - The accepted pixel is written at (row,col). If sof=1, it is written at (0,0) and the counters restart from there.
  - col increments and wraps at IMG_W-1. On wrap, row increments and wraps at IMG_H-1 back to 0.
  - The line buffers shift so the window holds rows row-2..row, cols col-2..col.
- Window valid: when row>=2 and col>=2 at acceptance. The output is for centre (row-1,col-1). Border pixels produce no result, so each frame yields (IMG_W-2)*(IMG_H-2) results in raster order.
- Pipeline, 2 stages, total latency 2 clk from write acceptance to FIFO push:
  - Stage 1, window p[r][c] with r,c in 0..2, top-left = 0,0:
    - Gx = (p02+2p12+p22)-(p00+2p10+p20)
    - Gy = (p20+2p21+p22)-(p00+2p01+p02)
    - Both signed, PIX_W+3 bits.
  - Stage 2: mag=|Gx|+|Gy|, saturated to 2^PIX_W-1.
    - mode=0: result=mag.
    - mode=1: result = all ones if mag>=threshold, else 0.
    - mode and threshold are sampled in stage 2.
- Read path:
  - An accepted read with the FIFO non-empty pops the head into bus_out on that edge.
  - An accepted read with the FIFO empty leaves bus_out unchanged and pops nothing.
  - bus_out otherwise holds its value.
- FIFO boundaries:
  - Push while full and no pop on the same edge: the result is dropped and overflow=1 until reset.
  - Push and pop on the same edge: both occur, the count is unchanged, and this is legal even when full.
  - fifo_empty and fifo_full are registered and reflect the count after the edge.
- sof arriving mid-frame abandons the partial frame. Results already pushed or in the pipeline are kept. New outputs appear only after rows 0..1 of the new frame.
- Reset mid-frame or mid-transaction returns everything to reset state at once. A strobe still low when reset releases is not accepted until data_strobe has been sampled high.

Test Plan:
- Reset, then read with FIFO empty -> bus_out=8'hFF, fifo_empty=1, overflow=0.
- IMG_W=IMG_H=4, 16-pixel frame with sof on the first pixel; left half 0, right half 100; mode=0 -> 4 results, each 255 (saturated); no result for border pixels.
- Same frame, uniform 50, mode=1, threshold=1 -> 4 results of 0x00; with the step image and threshold=200 -> 0xFF.
- Hold data_strobe low for 10 cycles on a write -> col advances by exactly 1; hold it low on a read -> exactly one pop.
- FIFO_DEPTH=2, 4x4 step frame with no reads -> fifo_full=1 after the 2nd result, overflow=1 after the 3rd; the first two reads return 255,255, then fifo_empty=1.
- Mid-frame sof after 6 pixels, then a full frame -> exactly 4 results, all from the new frame; assert reset mid-frame -> flags and bus_out return to reset values.
